// File: rtl/rep_decoder_seq.sv
// ============================================================================
// rep_decoder_seq : multi-cycle repetition-code decoder, BPC groups per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module rep_decoder_seq #(
  parameter int MAXBITS = 8,
  parameter int REP     = 3,
  parameter int BPC     = 2,
  localparam int SW     = $clog2(MAXBITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SW-1:0]          size,
  input  logic [MAXBITS*REP-1:0] rstring,
  output logic                   busy,
  output logic [MAXBITS-1:0]     dstring,
  output logic                   done,
  output logic [SW-1:0]          corr_cnt,
  output logic                   uncorr
);

  localparam int IW = $clog2(MAXBITS + BPC + 1);
  localparam int CW = $clog2(REP + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [SW-1:0] SIZE_MAX = SW'(MAXBITS);
  localparam logic [SW-1:0] ONE      = SW'(1);
  localparam logic [IW-1:0] STEP     = IW'(BPC);
  localparam logic [CW:0]   REP_W    = (CW + 1)'(REP);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_end;
  logic [IW-1:0]          size_ext;
  logic [SW-1:0]          size_q;
  logic [SW-1:0]          size_clamped;
  logic [MAXBITS*REP-1:0] rstr_q;
  logic [MAXBITS-1:0]     grp_bit;
  logic [MAXBITS-1:0]     grp_tie;
  logic [MAXBITS-1:0]     grp_corr;
  logic [MAXBITS-1:0]     grp_hit;
  logic [MAXBITS-1:0]     dstring_nxt;
  logic [SW-1:0]          corr_nxt;
  logic                   uncorr_nxt;
  logic                   accept;
  logic                   last_step;

  assign size_clamped = (size > SIZE_MAX) ? SIZE_MAX : size;
  assign accept       = start && (state != S_DECODE);
  assign size_ext     = IW'(size_q);
  assign idx_end      = idx + STEP;
  assign last_step    = (idx_end >= size_ext);

  // Every group votes in parallel; grp_hit picks the ones owned by this step.
  for (genvar i = 0; i < MAXBITS; i++) begin : g_grp
    logic [REP-1:0] copies;
    logic [CW-1:0]  ones;

    assign copies = rstr_q[i*REP +: REP];

    always_comb begin
      ones = '0;
      for (int k = 0; k < REP; k++) begin
        ones = ones + CW'(copies[k]);
      end
    end

    assign grp_bit[i]     = ({ones, 1'b0} > REP_W);
    assign grp_tie[i]     = ({ones, 1'b0} == REP_W);
    assign grp_corr[i]    = (ones != '0) && ({1'b0, ones} != REP_W) && !grp_tie[i];
    assign grp_hit[i]     = (IW'(i) >= idx) && (IW'(i) < idx_end) && (IW'(i) < size_ext);
    assign dstring_nxt[i] = grp_hit[i] ? grp_bit[i] : dstring[i];
  end

  always_comb begin
    corr_nxt   = corr_cnt;
    uncorr_nxt = uncorr | (|(grp_hit & grp_tie));
    for (int i = 0; i < MAXBITS; i++) begin
      if (grp_hit[i] && grp_corr[i]) begin
        corr_nxt = corr_nxt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (size_clamped == '0) ? S_DONE : S_DECODE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DECODE: state_nxt = last_step ? S_DONE : S_DECODE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_DECODE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      size_q   <= '0;
      rstr_q   <= '0;
      dstring  <= '0;
      corr_cnt <= '0;
      uncorr   <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      size_q   <= size_clamped;
      rstr_q   <= rstring;
      dstring  <= '0;
      corr_cnt <= '0;
      uncorr   <= 1'b0;
    end else if (state == S_DECODE) begin
      idx      <= idx_end;
      dstring  <= dstring_nxt;
      corr_cnt <= corr_nxt;
      uncorr   <= uncorr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rep_decoder_seq.sv
// ============================================================================
// tb_rep_decoder_seq : directed + random scoreboard bench for rep_decoder_seq
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rep_decoder_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, busy_a, done_a, unc_a;
  logic [3:0]  size_a, cc_a;
  logic [23:0] rs_a;
  logic [7:0]  ds_a;

  logic        start_b, busy_b, done_b, unc_b;
  logic [2:0]  size_b, cc_b;
  logic [7:0]  rs_b;
  logic [3:0]  ds_b;

  rep_decoder_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .size(size_a), .rstring(rs_a),
    .busy(busy_a), .dstring(ds_a), .done(done_a), .corr_cnt(cc_a), .uncorr(unc_a)
  );

  rep_decoder_seq #(.MAXBITS(4), .REP(2), .BPC(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .size(size_b), .rstring(rs_b),
    .busy(busy_b), .dstring(ds_b), .done(done_b), .corr_cnt(cc_b), .uncorr(unc_b)
  );

  typedef struct {
    logic [7:0] d;
    int         c;
    logic       u;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [23:0] rs, input int sz, input int rep,
                                 input int maxb, input int bpc);
    exp_t e;
    int   n;
    int   ones;
    e.d = '0;
    e.c = 0;
    e.u = 1'b0;
    n = (sz > maxb) ? maxb : sz;
    for (int i = 0; i < n; i++) begin
      ones = 0;
      for (int k = 0; k < rep; k++) ones += int'(rs[i*rep + k]);
      if (2 * ones > rep) e.d[i] = 1'b1;
      else if (2 * ones == rep) e.u = 1'b1;
      if (ones > 0 && ones < rep && 2 * ones != rep) e.c++;
    end
    e.lat = (n + bpc - 1) / bpc + 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; the start edge is the following posedge.
  task automatic start_word(input int which, input logic [23:0] rs, input int sz);
    if (which == 0) begin
      rs_a = rs; size_a = sz[3:0]; start_a = 1'b1;
      sb.push_back(model(rs, sz, 3, 8, 2));
    end else begin
      rs_b = rs[7:0]; size_b = sz[2:0]; start_b = 1'b1;
      sb.push_back(model(rs, sz, 2, 4, 2));
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // k0 = number of cycles already elapsed since the start edge.
  task automatic wait_done(input int which, input string tag, input int k0);
    exp_t e;
    int   k;
    logic busy_bad;
    e = sb.pop_front();
    k = k0;
    busy_bad = 1'b0;
    while (!(which != 0 ? done_b : done_a) && k < 40) begin
      if (!(which != 0 ? busy_b : busy_a)) busy_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, e.lat);
    chk({tag, "_busy_during"}, busy_bad, 0);
    chk({tag, "_busy_at_done"}, which != 0 ? busy_b : busy_a, 0);
    chk({tag, "_dstring"}, which != 0 ? {28'b0, ds_b} : {24'b0, ds_a}, e.d);
    chk({tag, "_corr_cnt"}, which != 0 ? {29'b0, cc_b} : {28'b0, cc_a}, e.c);
    chk({tag, "_uncorr"}, which != 0 ? unc_b : unc_a, e.u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] r;
    int          sz;
    int          seen;

    // Reset with random inputs
    rst = 1'b0;
    start_a = 1'b1; size_a = 4'($urandom); rs_a = 24'($urandom);
    start_b = 1'b1; size_b = 3'($urandom); rs_b = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_dstring_a", ds_a, 0);
    chk("rst_corr_a", cc_a, 0);
    chk("rst_uncorr_a", unc_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_dstring_b", ds_b, 0);
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic word: 2 corrections
    start_word(0, 24'b001_110_000_111, 4);
    wait_done(0, "basic", 1);
    chk("basic_dstring_const", ds_a, 8'b0000_0101);
    chk("basic_corr_const", cc_a, 2);
    repeat (2) @(negedge clk);
    chk("basic_done_single", done_a, 0);
    chk("basic_hold_dstring", ds_a, 8'b0000_0101);
    chk("basic_hold_corr", cc_a, 2);

    // size = 0
    start_word(0, 24'hFFFFFF, 0);
    wait_done(0, "size0", 1);

    // size clamped to MAXBITS
    start_word(0, 24'hFFFFFF, 12);
    wait_done(0, "clamp", 1);
    chk("clamp_dstring_const", ds_a, 8'hFF);
    @(negedge clk);

    // start during DECODE is ignored
    start_word(0, 24'b110_001_101_010_011_100_111_000, 8);
    @(negedge clk);
    rs_a = 24'hFFFFFF; size_a = 4'd2; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, "ignore", 3);

    // start during DONE is accepted back-to-back
    start_word(0, 24'b000_011_111_101_100, 5);
    wait_done(0, "b2b_first", 1);
    start_word(0, 24'b111_001_010_111_110_000, 6);
    wait_done(0, "b2b_second", 1);
    @(negedge clk);

    // Random words
    for (int n = 0; n < 10; n++) begin
      r  = 24'($urandom);
      sz = int'($urandom_range(0, 15));
      start_word(0, r, sz);
      wait_done(0, $sformatf("rand%0d", n), 1);
      if (n % 2 == 0) @(negedge clk);
    end

    // Reset mid-decode aborts with no done
    start_word(0, 24'hA5A5A5, 8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_dstring", ds_a, 0);
    chk("abort_corr", cc_a, 0);
    chk("abort_uncorr", unc_a, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Even REP instance: tie detection
    start_word(1, 24'b0000_10_11, 2);
    wait_done(1, "rep2_tie", 1);
    chk("rep2_dstring_const", ds_b, 4'b0001);
    chk("rep2_uncorr_const", unc_b, 1);
    @(negedge clk);
    start_word(1, 24'b00_11_01_11, 4);
    wait_done(1, "rep2_full", 1);
    @(negedge clk);
    start_word(1, 24'b11_11_11_11, 7);
    wait_done(1, "rep2_clamp", 1);
    @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
